// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its area-block completer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned TO_CNT_W   = 8;

  // Register map of the rectangle-area completer.
  localparam logic [APB_ADDR_W-1:0] SIDE_A_ADDR = 32'h0000_0000;
  localparam logic [APB_ADDR_W-1:0] SIDE_B_ADDR = 32'h0000_0004;
  localparam logic [APB_ADDR_W-1:0] AREA_ADDR   = 32'h0000_0008;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Last counter value allowed before an ACCESS phase is aborted.
  function automatic logic [TO_CNT_W-1:0] to_limit(input int unsigned cycles);
    return TO_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; flags the cycle in which the PREADY budget is spent.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  localparam logic [TO_CNT_W-1:0] LIMIT = to_limit(TIMEOUT_CYCLES);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, with a PREADY timeout
// and a held response until the consumer takes it.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e        state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;

  logic to_clr;
  logic to_inc;
  logic to_expired_c;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr       (to_clr),
    .inc       (to_inc),
    .expired_c (to_expired_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    to_clr      = 1'b0;
    to_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        to_clr    = 1'b1;
      end

      ACCESS: begin
        // A completing PREADY takes priority over a timeout in the same cycle.
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (to_expired_c) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          to_inc = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
